// File: rtl/mod_cnt.sv
// mod_cnt: up/down counter with a runtime upper bound (0..limit inclusive),
// synchronous load with clamping, and a registered terminal-count pulse.
// SATURATE selects between wrapping and holding at the bounds.
module mod_cnt #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_zero,
    output logic             at_limit
);

    logic [WIDTH-1:0] nxt_count;
    logic             nxt_tc;

    // Next-state: load beats enable; tc only asserts on a wrap event.
    always_comb begin
        nxt_count = count;
        nxt_tc    = 1'b0;
        if (load) begin
            // Loads above the bound are clamped so count never starts out of range.
            nxt_count = (count_in > limit) ? limit : count_in;
        end else if (en) begin
            if (up) begin
                if (count >= limit) begin
                    // At or past the bound (also covers a limit lowered under count).
                    nxt_count = SATURATE ? limit : '0;
                    nxt_tc    = !SATURATE;
                end else begin
                    nxt_count = count + 1'b1;
                end
            end else begin
                if (count > limit) begin
                    // Limit was lowered below count: snap back into range, no wrap.
                    nxt_count = limit;
                end else if (count == '0) begin
                    nxt_count = SATURATE ? '0 : limit;
                    nxt_tc    = !SATURATE;
                end else begin
                    nxt_count = count - 1'b1;
                end
            end
        end
    end

    // State register; reset clears any pending wrap/tc on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= nxt_count;
            tc    <= nxt_tc;
        end
    end

    assign at_zero  = (count == '0);
    assign at_limit = (count >= limit);

endmodule

// File: tb/tb_mod_cnt.sv
// Scoreboard bench for mod_cnt: one wrapping and one saturating instance
// share stimulus; each expectation names which instance it checks.
module tb_mod_cnt;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] count_in, limit;
    logic [3:0] cnt_w, cnt_s;
    logic       tc_w, tc_s, az_w, az_s, al_w, al_s;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        bit         sel;   // 0: wrapping instance, 1: saturating instance
        logic [3:0] cnt;
        logic       tc;
        logic       az;
        logic       al;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mod_cnt #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .count_in(count_in), .limit(limit),
        .count(cnt_w), .tc(tc_w), .at_zero(az_w), .at_limit(al_w)
    );

    mod_cnt #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .count_in(count_in), .limit(limit),
        .count(cnt_s), .tc(tc_s), .at_zero(az_s), .at_limit(al_s)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expected result.
    task automatic drv(input string tag, input bit sel, input bit r, input bit e,
                       input bit u, input bit ld, input logic [3:0] cin,
                       input logic [3:0] lim, input logic [3:0] ec, input bit etc);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up = u; load = ld; count_in = cin; limit = lim;
        x.tag = tag; x.sel = sel; x.cnt = ec; x.tc = etc;
        x.az = (ec == 4'd0); x.al = (ec >= lim);
        exp_q.push_back(x);
    endtask

    // Monitor: compare just after each rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk({x.tag, ".count"},    x.sel ? cnt_s : cnt_w, x.cnt);
            chk({x.tag, ".tc"},       x.sel ? tc_s  : tc_w,  x.tc);
            chk({x.tag, ".at_zero"},  x.sel ? az_s  : az_w,  x.az);
            chk({x.tag, ".at_limit"}, x.sel ? al_s  : al_w,  x.al);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; count_in = '0; limit = 4'd9;

        // Reset held with en=1, up=1, then released.
        for (int i = 0; i < 4; i++) drv("rst", 0, 1, 1, 1, 0, 0, 9, 0, 0);
        drv("rst_sat", 1, 1, 1, 1, 0, 0, 9, 0, 0);
        drv("rst_rel", 0, 0, 1, 1, 0, 0, 9, 1, 0);

        // Wrap up at limit 9.
        drv("up_ld7", 0, 0, 1, 1, 1, 7, 9, 7, 0);
        drv("up_8",   0, 0, 1, 1, 0, 0, 9, 8, 0);
        drv("up_9",   0, 0, 1, 1, 0, 0, 9, 9, 0);
        drv("up_0",   0, 0, 1, 1, 0, 0, 9, 0, 1);
        drv("up_1",   0, 0, 1, 1, 0, 0, 9, 1, 0);

        // Wrap down at limit 5.
        drv("dn_ld1", 0, 0, 0, 0, 1, 1, 5, 1, 0);
        drv("dn_0",   0, 0, 1, 0, 0, 0, 5, 0, 0);
        drv("dn_5",   0, 0, 1, 0, 0, 0, 5, 5, 1);
        drv("dn_4",   0, 0, 1, 0, 0, 0, 5, 4, 0);

        // Saturating instance: holds at both bounds.
        drv("sat_ld14", 1, 0, 0, 1, 1, 14, 15, 14, 0);
        for (int i = 0; i < 3; i++) drv("sat_up", 1, 0, 1, 1, 0, 0, 15, 15, 0);
        drv("sat_ld2",  1, 0, 0, 0, 1, 2, 15, 2, 0);
        drv("sat_dn1",  1, 0, 1, 0, 0, 0, 15, 1, 0);
        drv("sat_dn0",  1, 0, 1, 0, 0, 0, 15, 0, 0);
        drv("sat_dn0h", 1, 0, 1, 0, 0, 0, 15, 0, 0);
        drv("sat_ld12", 1, 0, 0, 1, 1, 12, 15, 12, 0);
        drv("sat_lim4", 1, 0, 1, 1, 0, 0, 4, 4, 0);

        // Load clamp, then reset beating load.
        drv("clamp",   0, 0, 1, 1, 1, 12, 6, 6, 0);
        drv("rst_ld",  0, 1, 1, 1, 1, 3, 6, 0, 0);

        // Limit lowered under count: up wraps, down snaps to limit.
        drv("lo_ld12", 0, 0, 0, 1, 1, 12, 15, 12, 0);
        drv("lo_up",   0, 0, 1, 1, 0, 0, 4, 0, 1);
        drv("lo_ld12b",0, 0, 0, 1, 1, 12, 15, 12, 0);
        drv("lo_dn",   0, 0, 1, 0, 0, 0, 4, 4, 0);

        // limit 0: tc every enabled cycle, then reset kills the pulse.
        for (int i = 0; i < 3; i++) drv("lim0_up", 0, 0, 1, 1, 0, 0, 0, 0, 1);
        drv("lim0_dn",  0, 0, 1, 0, 0, 0, 0, 0, 1);
        drv("rst_tc",   0, 1, 1, 1, 0, 0, 0, 0, 0);

        // Hold with en=0.
        drv("hold_ld3", 0, 0, 0, 1, 1, 3, 9, 3, 0);
        drv("hold",     0, 0, 0, 1, 0, 0, 9, 3, 0);
        drv("hold2",    0, 0, 0, 0, 0, 0, 9, 3, 0);

        // Full binary range from 0: two wraps, tc right after each 15->0.
        drv("full_rst", 0, 1, 0, 1, 0, 0, 15, 0, 0);
        for (int k = 1; k <= 32; k++)
            drv("full", 0, 0, 1, 1, 0, 0, 15, 4'(k % 16), (k % 16) == 0);

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_cnt.md
MOD_CNT -- requirements
Module: mod_cnt

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 means the counter wraps at its bounds; 1 means it holds at its bounds.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port en, input, 1 bit: count enable.
REQ-006 Port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 Port load, input, 1 bit: synchronous load of count_in.
REQ-008 Port count_in, input, WIDTH bits: load value.
REQ-009 Port limit, input, WIDTH bits: runtime upper bound; the count range is 0..limit inclusive.
REQ-010 Port count, output, WIDTH bits: current count, registered.
REQ-011 Port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-012 Port at_zero, output, 1 bit: combinational; 1 when count == 0.
REQ-013 Port at_limit, output, 1 bit: combinational; 1 when count >= limit.

Function
REQ-014 Update priority, evaluated each rising edge: rst > load > en > hold.
REQ-015 Load with count_in <= limit: count := count_in.
REQ-016 Load with count_in > limit: count := limit (clamped).
REQ-017 tc on a load cycle: tc := 0; en is ignored on that cycle.
REQ-018 en=0 with no load: count holds; tc := 0.
REQ-019 Up, en=1, count < limit: count := count+1; tc := 0.
REQ-020 Up, en=1, count >= limit, SATURATE=0: count := 0; tc := 1 for exactly the following cycle.
REQ-021 Up, en=1, count >= limit, SATURATE=1: count := limit; tc := 0.
REQ-022 Down, en=1, 0 < count <= limit: count := count-1; tc := 0.
REQ-023 Down, en=1, count == 0, SATURATE=0: count := limit; tc := 1 for exactly the following cycle.
REQ-024 Down, en=1, count == 0, SATURATE=1: count := 0; tc := 0.
REQ-025 Down, en=1, count > limit (limit lowered mid-count): count := limit; tc := 0.
REQ-026 limit == 0: count stays at 0 while enabled; in wrap mode, tc pulses on every enabled cycle.
REQ-027 Arithmetic is unsigned, modulo 2^WIDTH; limit = 2^WIDTH-1 gives the full binary range with natural wrap.
REQ-028 up and limit are sampled on the same edge as en; a direction or limit change takes effect on the next enabled step with no added latency.
REQ-029 Latency: count reflects a load or step one clock after the sampling edge.
REQ-030 Consecutive wrap events produce a tc pulse each cycle; tc is never stretched or merged.

Reset
REQ-031 While rst=1 at a rising edge: count := 0 and tc := 0, regardless of load and en.
REQ-032 Reset asserted mid-count or mid-tc-pulse takes effect on that edge; no pending wrap or tc survives reset.
REQ-033 After rst is released, counting resumes from 0 on the first edge at which en=1.
REQ-034 Before the first reset, count and tc are don't-care; the bench asserts rst for at least 1 cycle before checking outputs.

Verification (WIDTH=4)
REQ-035 Reset: drive rst=1 for 4 cycles with en=1 and up=1 -> count=0, tc=0, at_zero=1 throughout; release -> count=1 one edge later.
REQ-036 Wrap up: SATURATE=0, limit=9, load 7, then en=1, up=1 for 4 cycles -> count 8, 9, 0, 1; tc=1 only in the cycle count=0.
REQ-037 Wrap down and saturate: SATURATE=0, limit=5, count=1, down for 3 cycles -> count 0, 5, 4, with tc=1 when count=5; then SATURATE=1, limit=15, count=14, up for 3 cycles -> count 15, 15, 15, tc=0, at_limit=1.
REQ-038 Load clamp and priority: limit=6, load=1, en=1, count_in=12 -> count=6, tc=0; then load=1, rst=1 on the same edge -> count=0.
REQ-039 Limit lowered mid-count: count=12, limit changes to 4 -> up step gives count 0 with tc=1 (wrap mode); a down step instead gives count 4 with tc=0.
REQ-040 Full range: limit=15, SATURATE=0, 32 up-cycles from 0 -> count sequence 0..15 twice, with exactly 2 tc pulses, each after the 15->0 transition.
